// File: rtl/iter_ctrl_pkg.sv
// Shared types and helpers for the iteration run controller.
package iter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Watchdog trip point: one full sweep plus two cycles of wrap-pulse latency slack.
    function automatic int unsigned wdog_limit(input int unsigned width);
        return (32'd1 << width) + 32'd2;
    endfunction

endpackage

// File: rtl/iter_ctrl_wdog.sv
// Wrap watchdog for iter_ctrl; only compiled when ITER_CTRL_WDOG_EN is defined.
// Counts RUN cycles since the last wrap (or run entry) and flags a missing wrap.
`ifdef ITER_CTRL_WDOG_EN
module iter_ctrl_wdog
    import iter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic hit_o
);

    localparam int          CW  = WIDTH + 2;
    localparam int unsigned LIM = wdog_limit(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (run_i)
            cnt_d = cnt_q + 1'b1;
    end

    // Trips on the edge where the count would reach the limit; a same-cycle wrap takes precedence.
    assign hit_o = run_i && !clr_i && (cnt_q == CW'(LIM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule
`endif

// File: rtl/iter_ctrl.sv
// Run controller beside the inner counter: runs num_iter sweeps per start, then pulses done.
// Optional wrap watchdog is enabled by defining ITER_CTRL_WDOG_EN.
module iter_ctrl
    import iter_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              abort,
    output logic              cnt_en,
    input  logic              cnt_wrap,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ITER_W-1:0] iter_idx,
    output logic              wdog_err,
    output logic [1:0]        state_o
);

    // Handshake: start is a request sampled only in IDLE (no queueing); each accepted start
    // produces exactly one terminating pulse -- done, aborted, or (watchdog build) wdog_err set.
    state_t            state_q;
    logic [ITER_W-1:0] num_iter_q;
    logic [ITER_W-1:0] iter_idx_q;
    logic [ITER_W-1:0] iter_idx_d;
    logic              cnt_en_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic              start_ok;
    logic              last_wrap;
    logic              wdog_hit;

    assign start_ok   = (state_q == IDLE) && start && !abort;
    assign iter_idx_d = iter_idx_q + 1'b1;
    assign last_wrap  = cnt_wrap && (iter_idx_d == num_iter_q);

`ifdef ITER_CTRL_WDOG_EN
    logic wdog_err_q;

    iter_ctrl_wdog #(
        .WIDTH (WIDTH)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .run_i (state_q == RUN),
        .clr_i (start_ok || ((state_q == RUN) && cnt_wrap)),
        .hit_o (wdog_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdog_err_q <= 1'b0;
        else if (start_ok)
            wdog_err_q <= 1'b0;
        else if ((state_q == RUN) && !abort && !last_wrap && wdog_hit)
            wdog_err_q <= 1'b1;
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_iter_q <= '0;
            iter_idx_q <= '0;
            cnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        num_iter_q <= num_iter;
                        iter_idx_q <= '0;
                        if (num_iter != '0) begin
                            cnt_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    // The wrap is counted even when abort wins the same edge.
                    if (cnt_wrap)
                        iter_idx_q <= iter_idx_d;
                    if (abort) begin
                        cnt_en_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (last_wrap) begin
                        cnt_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (wdog_hit) begin
                        cnt_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    cnt_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign cnt_en   = cnt_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign iter_idx = iter_idx_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_iter_ctrl.sv
// Directed bench for iter_ctrl with a behavioural inner counter (WIDTH=3, 8-cycle sweeps).
module tb_iter_ctrl;

    localparam int WIDTH  = 3;
    localparam int ITER_W = 16;
    localparam int SWEEP  = 1 << WIDTH;
    localparam int EW     = 2 + ITER_W + 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] K_DONE = 2'b01;
    localparam logic [1:0] K_ABRT = 2'b10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ITER_W-1:0] num_iter;
    logic              abort;
    logic              cnt_en;
    logic              cnt_wrap;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ITER_W-1:0] iter_idx;
    logic              wdog_err;
    logic [1:0]        state_o;

    logic [WIDTH-1:0]  ctr_q;
    logic              wrap_q;
    logic              wrap_kill;
    logic              wrap_inj;

    int                cyc;
    int                vectors;
    int                miscompares;
    logic [EW-1:0]     exp_q[$];

    iter_ctrl #(
        .WIDTH  (WIDTH),
        .ITER_W (ITER_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_iter (num_iter),
        .abort    (abort),
        .cnt_en   (cnt_en),
        .cnt_wrap (cnt_wrap),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .iter_idx (iter_idx),
        .wdog_err (wdog_err),
        .state_o  (state_o)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- inner counter model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q  <= '0;
            wrap_q <= 1'b0;
        end else if (!cnt_en) begin
            ctr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ctr_q  <= ctr_q + 1'b1;
            wrap_q <= (ctr_q == {WIDTH{1'b1}});
        end
    end

    assign cnt_wrap = (wrap_q && !wrap_kill) || wrap_inj;

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues a start; returns t = index of the edge that sampled it.
    task automatic do_start(input int n, output int t);
        start    = 1'b1;
        num_iter = ITER_W'(n);
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] kind, input int idx, input int at);
        exp_q.push_back({kind, ITER_W'(idx), 32'(at)});
    endtask

    // ---------------- monitor: pops on every done/aborted pulse ----------------
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        if (rst_n && (done || aborted)) begin
            got = {aborted, done, iter_idx, 32'(cyc)};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got %0h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL pulse: got kind=%b idx=%0d cyc=%0d expected kind=%b idx=%0d cyc=%0d",
                             got[EW-1 -: 2], got[32 +: ITER_W], got[31:0],
                             exp[EW-1 -: 2], exp[32 +: ITER_W], exp[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        num_iter    = '0;
        abort       = 1'b0;
        wrap_kill   = 1'b0;
        wrap_inj    = 1'b0;

        #12;
        chk("rst_state",    32'(state_o),  32'(S_IDLE));
        chk("rst_cnt_en",   32'(cnt_en),   0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_done",     32'(done),     0);
        chk("rst_aborted",  32'(aborted),  0);
        chk("rst_iter_idx", 32'(iter_idx), 0);
        chk("rst_wdog_err", 32'(wdog_err), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal run, N=3: wraps seen at t+9, t+17, t+25; done on edge t+25.
        do_start(3, t);
        push_exp(K_DONE, 3, t + 1 + 3 * SWEEP);
        chk("n3_cnt_en_on", 32'(cnt_en), 1);
        chk("n3_busy_on",   32'(busy),   1);
        chk("n3_state_run", 32'(state_o), 32'(S_RUN));
        goto(t + SWEEP);
        chk("n3_idx_pre", 32'(iter_idx), 0);
        goto(t + 1 + SWEEP);
        chk("n3_idx1", 32'(iter_idx), 1);
        goto(t + 1 + 2 * SWEEP);
        chk("n3_idx2", 32'(iter_idx), 2);
        goto(t + 1 + 3 * SWEEP);
        chk("n3_idx3",      32'(iter_idx), 3);
        chk("n3_cnt_en_off", 32'(cnt_en),  0);
        chk("n3_busy_off",  32'(busy),     0);
        chk("n3_state_done", 32'(state_o), 32'(S_DONE));
        goto(t + 2 + 3 * SWEEP);
        chk("n3_state_idle", 32'(state_o), 32'(S_IDLE));
        chk("n3_idx_hold",   32'(iter_idx), 3);

        // N=0: straight to DONE, counter never enabled, iter_idx cleared.
        do_start(0, t);
        push_exp(K_DONE, 0, t);
        chk("n0_cnt_en",     32'(cnt_en),  0);
        chk("n0_state_done", 32'(state_o), 32'(S_DONE));
        goto(t + 1);
        chk("n0_state_idle", 32'(state_o), 32'(S_IDLE));
        chk("n0_idx",        32'(iter_idx), 0);
        chk("n0_cnt_en2",    32'(cnt_en),  0);

        // N=5, abort after the 2nd wrap.
        do_start(5, t);
        goto(t + 1 + 2 * SWEEP);
        chk("ab_idx2", 32'(iter_idx), 2);
        abort = 1'b1;
        push_exp(K_ABRT, 2, t + 2 + 2 * SWEEP);
        goto(t + 2 + 2 * SWEEP);
        abort = 1'b0;
        chk("ab_cnt_en", 32'(cnt_en),  0);
        chk("ab_busy",   32'(busy),    0);
        chk("ab_state",  32'(state_o), 32'(S_IDLE));
        goto(t + 2 + 5 * SWEEP);
        chk("ab_idx_hold", 32'(iter_idx), 2);

        // Start while busy and while in DONE, then a stray wrap in IDLE: all ignored.
        do_start(2, t);
        push_exp(K_DONE, 2, t + 1 + 2 * SWEEP);
        goto(t + 3);
        start    = 1'b1;
        num_iter = 16'd7;
        goto(t + 4);
        start = 1'b0;
        goto(t + 1 + 2 * SWEEP);
        chk("sb_state_done", 32'(state_o), 32'(S_DONE));
        start = 1'b1;
        goto(t + 2 + 2 * SWEEP);
        start = 1'b0;
        chk("sb_state_idle", 32'(state_o), 32'(S_IDLE));
        chk("sb_busy",       32'(busy),    0);
        chk("sb_idx",        32'(iter_idx), 2);
        goto(t + 4 + 2 * SWEEP);
        wrap_inj = 1'b1;
        goto(t + 5 + 2 * SWEEP);
        wrap_inj = 1'b0;
        chk("stray_idx",   32'(iter_idx), 2);
        chk("stray_state", 32'(state_o), 32'(S_IDLE));

        // Start and abort together in IDLE: abort wins.
        start    = 1'b1;
        abort    = 1'b1;
        num_iter = 16'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_state",  32'(state_o), 32'(S_IDLE));
        chk("sa_cnt_en", 32'(cnt_en),  0);
        chk("sa_idx",    32'(iter_idx), 2);

        // Abort on the same edge as the final wrap: aborted, wrap still counted.
        do_start(1, t);
        goto(t + SWEEP);
        abort = 1'b1;
        push_exp(K_ABRT, 1, t + 1 + SWEEP);
        goto(t + 1 + SWEEP);
        abort = 1'b0;
        chk("abf_idx",   32'(iter_idx), 1);
        chk("abf_state", 32'(state_o), 32'(S_IDLE));
        goto(t + 3 + SWEEP);

        // Asynchronous reset mid-run, then a clean run from zero.
        do_start(4, t);
        goto(t + 1 + SWEEP);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state",  32'(state_o), 32'(S_IDLE));
        chk("ar_cnt_en", 32'(cnt_en),  0);
        chk("ar_busy",   32'(busy),    0);
        chk("ar_idx",    32'(iter_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(1, t);
        push_exp(K_DONE, 1, t + 1 + SWEEP);
        chk("ar2_idx0", 32'(iter_idx), 0);
        goto(t + 1 + SWEEP);
        chk("ar2_idx1", 32'(iter_idx), 1);
        goto(t + 3 + SWEEP);

`ifdef ITER_CTRL_WDOG_EN
        // Missing wraps: watchdog trips 10 cycles after run entry.
        wrap_kill = 1'b1;
        do_start(2, t);
        goto(t + SWEEP + 1);
        chk("wd_err_early", 32'(wdog_err), 0);
        goto(t + SWEEP + 2);
        chk("wd_err_set", 32'(wdog_err), 1);
        chk("wd_cnt_en",  32'(cnt_en),   0);
        chk("wd_state",   32'(state_o),  32'(S_IDLE));
        wrap_kill = 1'b0;
        goto(t + SWEEP + 6);
        chk("wd_sticky", 32'(wdog_err), 1);
        do_start(1, t);
        push_exp(K_DONE, 1, t + 1 + SWEEP);
        chk("wd_clear", 32'(wdog_err), 0);
        goto(t + 3 + SWEEP);
`else
        chk("wd_tied0", 32'(wdog_err), 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
